// File: rtl/stream_fork3.sv
// Three-way broadcast fork: one upstream word is held and offered to three consumers.
// Upstream is released once every branch has taken the word; per-branch done bits absorb skew.
module stream_fork3 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m0_valid,
    input  logic              m0_ready,
    output logic [DATA_W-1:0] m0_data,
    output logic              m1_valid,
    input  logic              m1_ready,
    output logic [DATA_W-1:0] m1_data,
    output logic              m2_valid,
    input  logic              m2_ready,
    output logic [DATA_W-1:0] m2_data,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic              full;
    logic [DATA_W-1:0] hold_q;
    logic [2:0]        done;
    logic [CNT_W-1:0]  cnt;

    logic [2:0] branch_valid;
    logic [2:0] branch_ready;
    logic [2:0] hs;
    logic [2:0] fin;
    logic       complete;
    logic       acc;

    // Valids come straight from flops so branch outputs never see the downstream readies.
    assign branch_valid = {3{full}} & ~done;
    assign branch_ready = {m2_ready, m1_ready, m0_ready};
    assign hs           = branch_valid & branch_ready;
    assign fin          = done | hs;
    assign complete     = full & (&fin);

    // Refill in the completing cycle so all-ready streaming runs one word per clock.
    assign s_ready = ~full | complete;
    assign acc     = s_valid & s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            hold_q <= '0;
            done   <= 3'b000;
        end else if (acc) begin
            full   <= 1'b1;
            hold_q <= s_data;
            done   <= 3'b000;
        end else if (complete) begin
            full <= 1'b0;
            done <= 3'b000;
        end else if (full) begin
            done <= fin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (complete) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign m0_valid = branch_valid[0];
    assign m1_valid = branch_valid[1];
    assign m2_valid = branch_valid[2];
    assign m0_data  = hold_q;
    assign m1_data  = hold_q;
    assign m2_data  = hold_q;
    assign busy     = full;
    assign xfer_cnt = cnt;

endmodule

// File: tb/tb_stream_fork3.sv
// Directed bench for stream_fork3: a scoreboard of accepted words is replayed per branch
// at every downstream handshake, alongside directed checks of ready/valid/counter behaviour.
module tb_stream_fork3;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m0_valid, m1_valid, m2_valid;
    logic          m0_ready = 1'b0, m1_ready = 1'b0, m2_ready = 1'b0;
    logic [DW-1:0] m0_data, m1_data, m2_data;
    logic          busy;
    logic [CW-1:0] xfer_cnt;

    always #5 clk = ~clk;

    stream_fork3 #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data),
        .m2_valid(m2_valid), .m2_ready(m2_ready), .m2_data(m2_data),
        .busy(busy), .xfer_cnt(xfer_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Every accepted word, in order; rd[i] is the next index branch i must deliver.
    logic [DW-1:0] sent[$];
    int            rd[3];
    int            hs_n[3];
    logic [2:0]    prev_pend = 3'b000;
    logic [DW-1:0] prev_data[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [2:0]    v;
        logic [2:0]    r;
        logic [DW-1:0] d[3];
        v = {m2_valid, m1_valid, m0_valid};
        r = {m2_ready, m1_ready, m0_ready};
        d[0] = m0_data;
        d[1] = m1_data;
        d[2] = m2_data;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (prev_pend[i]) begin
                    chk($sformatf("hold_valid_b%0d", i), {31'd0, v[i]}, 32'd1);
                    chk($sformatf("hold_data_b%0d", i), d[i], prev_data[i]);
                end
                if (v[i] && r[i]) begin
                    if (rd[i] < sent.size()) begin
                        chk($sformatf("sb_data_b%0d", i), d[i], sent[rd[i]]);
                    end else begin
                        checks++;
                        errors++;
                        $error("FAIL sb_extra_b%0d: observed word %h with nothing pending, expected none", i, d[i]);
                    end
                    rd[i]++;
                    hs_n[i]++;
                end
                prev_pend[i] = v[i] & ~r[i];
                prev_data[i] = d[i];
            end
            if (s_valid && s_ready) sent.push_back(s_data);
        end else begin
            prev_pend = 3'b000;
        end
    end

    initial begin
        logic [7:0]    exp_cnt;
        logic [DW-1:0] x_word;
        logic [DW-1:0] y_word;
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;
        exp_cnt = 8'h00;
        x_word  = 32'hCAFE_0001;
        y_word  = 32'hBEEF_0002;
        w1      = 32'h5A5A_0001;
        w2      = 32'h5A5A_0002;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 0;
            hs_n[i] = 0;
        end

        // Power-on reset
        #12;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_valids", {29'd0, m2_valid, m1_valid, m0_valid}, 32'd0);
        chk("rst_m0_data", m0_data, 32'd0);
        chk("rst_m2_data", m2_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {24'd0, xfer_cnt}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Back-to-back streaming, all branches ready
        m0_ready = 1'b1; m1_ready = 1'b1; m2_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'hA5A5_0000 + i;
            #3;
            chk("stream_s_ready", {31'd0, s_ready}, 32'd1);
            cyc();
        end
        s_valid = 1'b0;
        cyc();
        cyc();
        exp_cnt = exp_cnt + 8'd16;
        chk("stream_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
        chk("stream_hs_b0", hs_n[0], 32'd16);
        chk("stream_hs_b1", hs_n[1], 32'd16);
        chk("stream_hs_b2", hs_n[2], 32'd16);
        chk("stream_busy", {31'd0, busy}, 32'd0);

        // Staggered branch acceptance
        m0_ready = 1'b0; m1_ready = 1'b0; m2_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h1234_5678;
        #3;
        chk("stag_idle_ready", {31'd0, s_ready}, 32'd1);
        cyc();
        s_valid = 1'b0;
        m0_ready = 1'b1;
        #3;
        chk("stag_c1_s_ready", {31'd0, s_ready}, 32'd0);
        cyc();
        m0_ready = 1'b0;
        #3;
        chk("stag_c2_m0_valid", {31'd0, m0_valid}, 32'd0);
        chk("stag_c2_m2_valid", {31'd0, m2_valid}, 32'd1);
        chk("stag_c2_s_ready", {31'd0, s_ready}, 32'd0);
        cyc();
        m2_ready = 1'b1;
        #3;
        chk("stag_c3_s_ready", {31'd0, s_ready}, 32'd0);
        cyc();
        m2_ready = 1'b0;
        #3;
        chk("stag_c4_m2_valid", {31'd0, m2_valid}, 32'd0);
        chk("stag_c4_m1_valid", {31'd0, m1_valid}, 32'd1);
        chk("stag_c4_s_ready", {31'd0, s_ready}, 32'd0);
        chk("stag_c4_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
        cyc();
        m1_ready = 1'b1;
        #3;
        chk("stag_c5_s_ready", {31'd0, s_ready}, 32'd1);
        cyc();
        m1_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        #3;
        chk("stag_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
        chk("stag_busy", {31'd0, busy}, 32'd0);
        cyc();

        // Completion and new accept in the same cycle
        s_valid = 1'b1;
        s_data  = x_word;
        #3;
        cyc();
        s_valid = 1'b0;
        m0_ready = 1'b1; m1_ready = 1'b1;
        #3;
        cyc();
        m0_ready = 1'b0; m1_ready = 1'b0; m2_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = y_word;
        #3;
        chk("ca_s_ready", {31'd0, s_ready}, 32'd1);
        chk("ca_m2_valid", {31'd0, m2_valid}, 32'd1);
        chk("ca_m0_valid", {31'd0, m0_valid}, 32'd0);
        cyc();
        exp_cnt = exp_cnt + 8'd1;
        s_valid = 1'b0;
        m2_ready = 1'b0;
        #3;
        chk("ca_valids", {29'd0, m2_valid, m1_valid, m0_valid}, 32'd7);
        chk("ca_m0_data", m0_data, y_word);
        chk("ca_m1_data", m1_data, y_word);
        chk("ca_m2_data", m2_data, y_word);
        chk("ca_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
        m0_ready = 1'b1; m1_ready = 1'b1; m2_ready = 1'b1;
        cyc();
        exp_cnt = exp_cnt + 8'd1;
        m0_ready = 1'b0; m1_ready = 1'b0; m2_ready = 1'b0;
        #3;
        chk("ca_drain_busy", {31'd0, busy}, 32'd0);
        chk("ca_drain_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
        cyc();

        // Branch 1 stalled while upstream keeps offering
        m0_ready = 1'b1; m2_ready = 1'b1; m1_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = w1;
        #3;
        cyc();
        s_data = w2;
        for (int j = 0; j < 20; j++) begin
            #3;
            chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
            chk("stall_m1_valid", {31'd0, m1_valid}, 32'd1);
            chk("stall_m1_data", m1_data, w1);
            if (j > 0) begin
                chk("stall_m0_valid", {31'd0, m0_valid}, 32'd0);
                chk("stall_m2_valid", {31'd0, m2_valid}, 32'd0);
            end
            cyc();
        end
        chk("stall_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
        m1_ready = 1'b1;
        #3;
        chk("stall_release_ready", {31'd0, s_ready}, 32'd1);
        cyc();
        exp_cnt = exp_cnt + 8'd1;
        s_valid = 1'b0;
        #3;
        chk("stall_next_data", m1_data, w2);
        chk("stall_next_valids", {29'd0, m2_valid, m1_valid, m0_valid}, 32'd7);
        cyc();
        exp_cnt = exp_cnt + 8'd1;
        m0_ready = 1'b0; m1_ready = 1'b0; m2_ready = 1'b0;
        #3;
        chk("stall_cnt_end", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
        chk("stall_busy_end", {31'd0, busy}, 32'd0);
        cyc();

        // Asynchronous reset with a partially delivered word (done=010)
        s_valid = 1'b1;
        s_data  = 32'h0D0D_0001;
        #3;
        cyc();
        s_valid = 1'b0;
        m1_ready = 1'b1;
        #3;
        cyc();
        m1_ready = 1'b0;
        #1;
        chk("mid_m1_valid", {31'd0, m1_valid}, 32'd0);
        chk("mid_m0_valid", {31'd0, m0_valid}, 32'd1);
        chk("mid_s_ready", {31'd0, s_ready}, 32'd0);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) rd[i] = sent.size();
        exp_cnt = 8'h00;
        #1;
        chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("mid_rst_valids", {29'd0, m2_valid, m1_valid, m0_valid}, 32'd0);
        chk("mid_rst_cnt", {24'd0, xfer_cnt}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_data", m1_data, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        m0_ready = 1'b1; m1_ready = 1'b1; m2_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #3;
            chk("post_rst_valids", {29'd0, m2_valid, m1_valid, m0_valid}, 32'd0);
            cyc();
        end

        // Counter wrap
        for (int i = 0; i < 255; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            cyc();
        end
        s_valid = 1'b0;
        cyc();
        cyc();
        exp_cnt = exp_cnt + 8'd255;
        chk("wrap_ff", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
        s_valid = 1'b1;
        s_data  = $urandom;
        cyc();
        s_valid = 1'b0;
        cyc();
        cyc();
        exp_cnt = exp_cnt + 8'd1;
        chk("wrap_00", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
        s_valid = 1'b1;
        s_data  = $urandom;
        cyc();
        s_valid = 1'b0;
        cyc();
        cyc();
        exp_cnt = exp_cnt + 8'd1;
        chk("wrap_01", {24'd0, xfer_cnt}, {24'd0, exp_cnt});

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sb_drained_b%0d", i), rd[i], sent.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_fork3.md
Name: stream_fork3

Overview:
- Three-way broadcast fork for a valid/ready stream. One upstream word is delivered to three downstream consumers.
- The upstream side is released only when all three branches have accepted the word. This is the distributing counterpart of a 3-input AND-join.
- Sits between one producer and three independent consumers on the SoC interconnect. It decouples branch stalls through per-branch completion tracking and a registered holding stage.

Parameters:
- DATA_W, 32, width of the data word.
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  fork can accept an upstream word this cycle.
- s_data  input  DATA_W  upstream word.
- m0_valid  output  1  branch 0 word valid.
- m0_ready  input  1  branch 0 consumer ready.
- m0_data  output  DATA_W  branch 0 word.
- m1_valid / m1_ready / m1_data  same as branch 0, for branch 1.
- m2_valid / m2_ready / m2_data  same as branch 0, for branch 2.
- busy  output  1  holding register occupied.
- xfer_cnt  output  CNT_W  count of fully completed broadcasts; wraps modulo 2^CNT_W.

Behaviour:
- State:
  - full: holding register occupied.
  - hold_q[DATA_W-1:0]: held word.
  - done[2:0]: branch i has already accepted the current word.
  - cnt[CNT_W-1:0]: completed-broadcast counter.
- Reset (async, rst_n=0): full=0, done=000, hold_q=0, cnt=0. Outputs during and after reset:
  - s_ready=1
  - m*_valid=0
  - m*_data=0
  - busy=0
  - xfer_cnt=0
- Reset mid-transfer discards the held word and any partial completion. No branch sees a re-presentation after reset.
- Branch outputs:
  - mi_valid = full & ~done[i], combinational from flops only.
  - mi_data = hold_q on all three branches.
- Handshakes:
  - hs_i = mi_valid & mi_ready.
  - fin_i = done[i] | hs_i.
  - complete = full & fin_0 & fin_1 & fin_2.
- Upstream ready: s_ready = ~full | complete. This gives full throughput of one word per cycle when all three readies are high.
  - s_ready depends combinationally on m*_ready.
  - s_ready must not depend on s_valid.
- Accept: acc = s_valid & s_ready. On acc: hold_q <= s_data, full <= 1, done <= 000.
- Complete without new accept: full <= 0, done <= 000, hold_q unchanged.
- Partial progress (full & ~complete): done[i] <= done[i] | hs_i. Branches that already accepted drop valid and stay low until the next word.
- Counter: cnt <= cnt + 1 on every complete. Wraps from 2^CNT_W-1 to 0 silently.
- Latency: a word accepted at edge N appears on all m*_valid/m*_data after edge N.
- Ordering: each branch sees words in upstream order, with no duplication and no loss.
- Protocol rules:
  - Once mi_valid is high, it stays high with stable mi_data until hs_i or reset.
  - The producer must hold s_data stable while s_valid & ~s_ready. The fork does not check this.
- Simultaneous events: completion and a new upstream accept in the same cycle load the new word and clear done. No bubble is inserted.
- busy = full.

Test Plan:
- Reset check: assert rst_n=0 mid-word with done=010. Required: s_ready=1, all mi_valid=0, xfer_cnt=0 immediately (asynchronous). After release, no stale word is presented.
- Streaming: all m*_ready=1, send 0xA5A5_0001..0xA5A5_0010 back-to-back. Required:
  - each branch receives 16 words in order, each exactly once;
  - s_ready stays 1 throughout;
  - xfer_cnt=16.
- Staggered branches: send 0x1234_5678 with ready pattern m0 at cycle 1, m2 at cycle 3, m1 at cycle 5. Required:
  - m0_valid drops after cycle 1 and m2_valid after cycle 3;
  - s_ready=0 until cycle 5, then 1 combinationally in cycle 5;
  - xfer_cnt increments once.
- Completion plus accept: with word X held and done=011, present word Y while m2_ready=1. Required:
  - Y is accepted the same cycle;
  - next cycle all three mi_valid=1 with data=Y.
- Stalled branch: hold m1_ready=0 for 20 cycles while s_valid=1. Required:
  - s_ready=0;
  - m1_data stable;
  - m0_valid and m2_valid are 0 after their single handshakes;
  - no second word is accepted.
- Counter wrap: run 256 broadcasts with CNT_W=8. Required: xfer_cnt returns to 0x00, then reads 0x01 after one more broadcast.
